// File: rtl/iter_multiplier.sv
// rtl/iter_multiplier.sv - multi-cycle shift-add WIDTHxWIDTH->2*WIDTH multiplier for MULT/MULTU
// Optional MULT_EARLY_EXIT_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module iter_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             MU,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

  state_t               state, state_n;
  logic [2*WIDTH-1:0]   a_sh, a_sh_n, acc, acc_n, prod;
  logic [WIDTH-1:0]     b_sh, b_sh_n, mag_a, mag_b, hi_n, lo_n;
  logic [CW-1:0]        count, count_n;
  logic                 neg, neg_n, busy_n, done_n;

  // Signed mode works on magnitudes; 0x80..0 negates to itself, which is the correct unsigned magnitude.
  assign mag_a = (!MU && multiplicand[WIDTH-1]) ? -multiplicand : multiplicand;
  assign mag_b = (!MU && multiplier[WIDTH-1])   ? -multiplier   : multiplier;
  assign prod  = neg ? -acc : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    a_sh_n  = a_sh;
    b_sh_n  = b_sh;
    acc_n   = acc;
    count_n = count;
    neg_n   = neg;
    busy_n  = busy;
    done_n  = 1'b0;
    hi_n    = hi;
    lo_n    = lo;
    case (state)
      IDLE: begin
        if (start) begin
          a_sh_n  = {{WIDTH{1'b0}}, mag_a};
          b_sh_n  = mag_b;
          acc_n   = '0;
          count_n = CW'(WIDTH);
          neg_n   = ~MU & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          busy_n  = 1'b1;
          state_n = CALC;
        end
      end
      CALC: begin
        // One extra cycle with count==0 hands over to SIGN, giving the WIDTH+2 latency.
        if (count == '0) begin
          state_n = SIGN;
        end else begin
          if (b_sh[0]) acc_n = acc + a_sh;
          a_sh_n  = a_sh << 1;
          b_sh_n  = b_sh >> 1;
          count_n = count - 1'b1;
`ifdef MULT_EARLY_EXIT_EN
          if (b_sh_n == '0) count_n = '0;
`endif
        end
      end
      SIGN: begin
        {hi_n, lo_n} = prod;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      count <= '0;
      neg   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      a_sh  <= a_sh_n;
      b_sh  <= b_sh_n;
      acc   <= acc_n;
      count <= count_n;
      neg   <= neg_n;
      busy  <= busy_n;
      done  <= done_n;
      hi    <= hi_n;
      lo    <= lo_n;
    end
  end

endmodule

// File: tb/tb_iter_multiplier.sv
// tb/tb_iter_multiplier.sv - scoreboard bench for iter_multiplier with a behavioural product/latency model
module tb_iter_multiplier;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mu = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  iter_multiplier #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .MU(mu),
    .multiplicand(a), .multiplier(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] prod;
    int          k;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   pass = 0;
  int   total = 0;
  logic [63:0] last = '0;
  logic        prev_done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [63:0] ref_prod(input logic m, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xe, ye;
    xe = m ? {32'h0, x} : {{32{x[31]}}, x};
    ye = m ? {32'h0, y} : {{32{y[31]}}, y};
    return xe * ye;
  endfunction

  function automatic int ref_lat(input logic m, input logic [31:0] y);
`ifdef MULT_EARLY_EXIT_EN
    longint mag;
    int     top;
    mag = m ? longint'(y) : ((y[31]) ? -longint'($signed(y)) : longint'(y));
    top = -1;
    for (int i = 0; i < 32; i++) if (mag[i]) top = i;
    return (top < 0) ? 3 : 3 + top;
`else
    return 34;
`endif
  endfunction

  // Called just after a negedge; start is sampled by the next posedge.
  task automatic issue(input logic m, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    mu = m; a = x; b = y; start = 1'b1;
    e.prod = ref_prod(m, x, y);
    e.k    = cyc + 1;
    e.lat  = ref_lat(m, y);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    mu = 1'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    if (!got) begin
      total++;
      $display("FAIL done_timeout: got no done expected done within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last = '0;
      prev_done = 1'b0;
    end else begin
      if (busy) chk("hold_hilo", {hi, lo}, last);
      if (done) begin
        chk("done_pulse", 64'(prev_done), 64'(0));
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_done: got done with %h expected none (cycle %0d)", {hi, lo}, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("product", {hi, lo}, e.prod);
          chk("latency", 64'(cyc - e.k), 64'(e.lat));
        end
        last = {hi, lo};
      end
      prev_done = done;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by 500000");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    chk("reset_hilo", {hi, lo}, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_done();
    issue(1'b0, 32'hFFFF_FFFD, 32'd7);         wait_done();
    issue(1'b0, 32'h8000_0000, 32'h8000_0000); wait_done();
    issue(1'b1, 32'h8000_0000, 32'h8000_0000); wait_done();
    issue(1'b1, 32'd5, 32'd3);                 wait_done();
    issue(1'b1, 32'd5, 32'd0);                 wait_done();
    issue(1'b0, 32'h0, 32'hFFFF_FFFF);         wait_done();

    // Start while busy must be ignored; the done-cycle start is accepted back-to-back.
    issue(1'b1, 32'd6, 32'd7);
    repeat (3) @(negedge clk);
    mu = 1'b1; a = 32'd9; b = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(1'b1, 32'd2, 32'd3);
    wait_done();

    // Reset mid-operation aborts with outputs cleared immediately.
    mu = 1'b1; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(1'b1, 32'd4, 32'd4); wait_done();

    for (int i = 0; i < 30; i++) begin
      logic        m;
      logic [31:0] x, y;
      m = 1'($urandom);
      x = pick();
      y = pick();
      issue(m, x, y);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(q.size()), 64'(0));
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
